vga_rect_fill: RTL and testbench
================================

VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 SHALL have parameter H_MAX, default 1280, meaning framebuffer width in pixels.
REQ-002 SHALL have parameter V_MAX, default 1024, meaning framebuffer height in pixels.
REQ-003 SHALL have parameter GATE_ACTIVE, default 1; when 1, writes are held off while the display scans active video.
REQ-004 SHALL have ports: clk_i input 1, the single clock; arstn_i input 1, asynchronous active-low reset.
REQ-005 SHALL have ports cmd_valid_i input 1 and cmd_ready_o output 1, the command handshake.
REQ-006 SHALL have ports cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i input 11 each, the inclusive rectangle corners.
REQ-007 SHALL have port cmd_color_i input 2, the color code (0 black, 1 white, 2 blue, 3 green).
REQ-008 SHALL have ports abort_i input 1 (cancel the fill) and pixel_enable_i input 1 (display active-video flag).
REQ-009 SHALL have write-port outputs addr_x_o output 11, addr_y_o output 11, color_o output 2 and we_o output 1.
REQ-010 SHALL have status outputs busy_o output 1, done_o output 1 (one-cycle pulse) and err_o output 1 (one-cycle pulse).

Function
REQ-011 SHALL implement FSM states IDLE, FILL and DONE.
REQ-012 SHALL assert cmd_ready_o only in IDLE; the handshake fires when cmd_valid_i and cmd_ready_o are both 1 on a rising edge.
REQ-013 SHALL reject a command on handshake if x0>x1, y0>y1, x1>=H_MAX or y1>=V_MAX: err_o pulses the next cycle, state stays IDLE, no writes.
REQ-014 SHALL latch all command fields on a valid handshake and enter FILL the next cycle with the cursor at (x0,y0).
REQ-015 SHALL assert we_o in FILL in every cycle where the stall condition is 0; stall is (GATE_ACTIVE and pixel_enable_i), else 0.
REQ-016 SHALL drive addr_x_o and addr_y_o from the registered cursor and color_o from the latched color; these outputs are valid whenever we_o is 1.
REQ-017 SHALL advance the cursor only on cycles with we_o=1: x+1, or x to x0 and y+1 when x==x1.
REQ-018 SHALL go from FILL to DONE after the write at (x1,y1); in DONE, done_o=1 for one cycle, then the FSM returns to IDLE.
REQ-019 SHALL issue exactly (x1-x0+1)*(y1-y0+1) writes per accepted command, in raster order, with no duplicates.
REQ-020 SHALL make the first write occur no earlier than 1 cycle after the handshake; with no stall, writes are back-to-back.
REQ-021 SHALL handle abort_i=1 in FILL: we_o=0 that same cycle, return to IDLE the next cycle, no done_o.
REQ-022 SHALL ignore abort_i in IDLE and DONE.
REQ-023 SHALL hold busy_o=1 exactly in FILL and DONE.
REQ-024 SHALL accept a new command in the cycle after the DONE state.
REQ-025 SHALL allow a full-screen fill (0,0)-(H_MAX-1,V_MAX-1); cursor arithmetic is 11-bit and never wraps.

Reset
REQ-026 SHALL, on arstn_i=0, immediately enter IDLE and force we_o=0, done_o=0, err_o=0, busy_o=0, addr_x_o=0, addr_y_o=0, color_o=0.
REQ-027 SHALL leave cmd_ready_o=1 after reset release.
REQ-028 SHALL abandon any in-progress fill when reset is asserted, with no further writes.

Structure
REQ-029 SHALL place the color-code enum (BLACK, WHITE, BLUE, GREEN) and the FSM state typedef in vga_pkg.
REQ-030 SHALL derive H_MAX and V_MAX defaults from vga_pkg maximum constants.
REQ-031 SHALL use one natural sub-module, vga_rect_cursor (x/y raster counter with load, step and last flag).

Verification
REQ-032 SHALL cover: rect (3,5)-(4,6), color 2, GATE_ACTIVE=0 -> writes (3,5),(4,5),(3,6),(4,6) on 4 consecutive cycles, then done_o one cycle later.
REQ-033 SHALL cover: x0=10, x1=9 -> err_o pulse, zero writes, cmd_ready_o stays 1.
REQ-034 SHALL cover: rect (0,0)-(7,0), GATE_ACTIVE=1, pixel_enable_i high for cycles 2-4 -> 8 writes, none during those cycles, order preserved.
REQ-035 SHALL cover: rect (0,0)-(99,99), abort_i at the 50th write -> exactly 49 writes, no done_o, IDLE next cycle.
REQ-036 SHALL cover: arstn_i low mid-fill -> all outputs 0 immediately; after release, a new 1x1 command at (1279,1023) gives exactly 1 write.
REQ-037 SHALL cover: a second cmd_valid_i held during a fill -> it is accepted only after done_o, and both fills complete.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg : shared types and constants for the rectangle fill engine
// Rev 1.0
// ----------------------------------------------------------------------------
package vga_pkg;

   localparam int c_COORD_W  = 11;
   localparam int VGA_H_MAX  = 1280;
   localparam int VGA_V_MAX  = 1024;

   typedef logic [c_COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      BLACK = 2'd0,
      WHITE = 2'd1,
      BLUE  = 2'd2,
      GREEN = 2'd3
   } color_e;

   typedef logic [1:0] state_t;

   localparam state_t c_ST_IDLE = 2'd0;
   localparam state_t c_ST_FILL = 2'd1;
   localparam state_t c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vga_rect_fill_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_rect_fill_if : command channel (valid/ready + rectangle + color)
// Rev 1.0
// ----------------------------------------------------------------------------
interface vga_rect_fill_if;

   logic             cmd_valid_i;
   logic             cmd_ready_o;
   vga_pkg::coord_t  cmd_x0_i;
   vga_pkg::coord_t  cmd_y0_i;
   vga_pkg::coord_t  cmd_x1_i;
   vga_pkg::coord_t  cmd_y1_i;
   vga_pkg::color_e  cmd_color_i;

   modport master (
      output cmd_valid_i, cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i, cmd_color_i,
      input  cmd_ready_o
   );

   modport slave (
      input  cmd_valid_i, cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i, cmd_color_i,
      output cmd_ready_o
   );

endinterface
`default_nettype wire

// File: rtl/vga_rect_cursor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_rect_cursor : x/y raster counter over an inclusive rectangle
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_rect_cursor
   import vga_pkg::*;
(
   input  logic   clk_i,
   input  logic   arstn_i,
   input  logic   load_i,
   input  logic   step_i,
   input  coord_t x0_i,
   input  coord_t y0_i,
   input  coord_t x1_i,
   input  coord_t y1_i,
   output coord_t x_o,
   output coord_t y_o,
   output logic   last_o
);

   coord_t x_q, x_d;
   coord_t y_q, y_d;
   coord_t x0_q, x1_q, y1_q;

   // The cursor never passes x1/y1, so 11-bit increments cannot wrap.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (load_i) begin
         x_d = x0_i;
         y_d = y0_i;
      end else if (step_i) begin
         if (x_q == x1_q) begin
            x_d = x0_q;
            y_d = y_q + coord_t'(1);
         end else begin
            x_d = x_q + coord_t'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         x_q  <= '0;
         y_q  <= '0;
         x0_q <= '0;
         x1_q <= '0;
         y1_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         if (load_i) begin
            x0_q <= x0_i;
            x1_q <= x1_i;
            y1_q <= y1_i;
         end
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = (x_q == x1_q) && (y_q == y1_q);

endmodule
`default_nettype wire

// File: rtl/vga_rect_fill.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_rect_fill : fills a rectangle of the framebuffer, one pixel per cycle
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_rect_fill
   import vga_pkg::*;
#(
   parameter int H_MAX       = VGA_H_MAX,
   parameter int V_MAX       = VGA_V_MAX,
   parameter int GATE_ACTIVE = 1
) (
   input  logic            clk_i,
   input  logic            arstn_i,
   vga_rect_fill_if.slave  cmd,
   input  logic            abort_i,
   input  logic            pixel_enable_i,
   output coord_t          addr_x_o,
   output coord_t          addr_y_o,
   output logic [1:0]      color_o,
   output logic            we_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o
);

   localparam logic c_GATE = (GATE_ACTIVE != 0);

   state_t state_q, state_d;
   color_e color_q;
   logic   err_q;

   logic   w_ready;
   logic   w_fire;
   logic   w_bad;
   logic   w_accept;
   logic   w_stall;
   logic   w_we;
   logic   w_last;

   assign w_ready  = (state_q == c_ST_IDLE);
   assign w_fire   = cmd.cmd_valid_i & w_ready;
   assign w_bad    = (cmd.cmd_x0_i > cmd.cmd_x1_i)
                   | (cmd.cmd_y0_i > cmd.cmd_y1_i)
                   | (32'(cmd.cmd_x1_i) >= 32'(H_MAX))
                   | (32'(cmd.cmd_y1_i) >= 32'(V_MAX));
   assign w_accept = w_fire & ~w_bad;
   assign w_stall  = c_GATE & pixel_enable_i;
   // Abort suppresses the write in the very cycle it is seen.
   assign w_we     = (state_q == c_ST_FILL) & ~w_stall & ~abort_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_IDLE: if (w_accept) state_d = c_ST_FILL;
         c_ST_FILL: begin
            if (abort_i)
               state_d = c_ST_IDLE;
            else if (w_we && w_last)
               state_d = c_ST_DONE;
         end
         c_ST_DONE: state_d = c_ST_IDLE;
         default:   state_d = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= c_ST_IDLE;
         color_q <= BLACK;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= w_fire & w_bad;
         if (w_accept)
            color_q <= cmd.cmd_color_i;
      end
   end

   vga_rect_cursor u_cursor (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .load_i  (w_accept),
      .step_i  (w_we),
      .x0_i    (cmd.cmd_x0_i),
      .y0_i    (cmd.cmd_y0_i),
      .x1_i    (cmd.cmd_x1_i),
      .y1_i    (cmd.cmd_y1_i),
      .x_o     (addr_x_o),
      .y_o     (addr_y_o),
      .last_o  (w_last)
   );

   assign cmd.cmd_ready_o = w_ready;
   assign color_o         = color_q;
   assign we_o            = w_we;
   assign busy_o          = (state_q == c_ST_FILL) | (state_q == c_ST_DONE);
   assign done_o          = (state_q == c_ST_DONE);
   assign err_o           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_vga_rect_fill : directed scoreboard bench for vga_rect_fill
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_vga_rect_fill;
   import vga_pkg::*;

   typedef struct packed {
      coord_t     x;
      coord_t     y;
      logic [1:0] c;
   } pix_t;

   logic       clk_i = 1'b0;
   logic       arstn_i;
   logic       abort_i;
   logic       pixel_enable_i;
   coord_t     addr_x_o, addr_y_o;
   logic [1:0] color_o;
   logic       we_o, busy_o, done_o, err_o;
   coord_t     ng_addr_x, ng_addr_y;
   logic [1:0] ng_color;
   logic       ng_we, ng_busy, ng_done, ng_err;

   vga_rect_fill_if cmd_if ();
   vga_rect_fill_if ng_if ();

   // Ungated twin sees the same commands; it shows what GATE_ACTIVE=0 does.
   assign ng_if.cmd_valid_i = cmd_if.cmd_valid_i;
   assign ng_if.cmd_x0_i    = cmd_if.cmd_x0_i;
   assign ng_if.cmd_y0_i    = cmd_if.cmd_y0_i;
   assign ng_if.cmd_x1_i    = cmd_if.cmd_x1_i;
   assign ng_if.cmd_y1_i    = cmd_if.cmd_y1_i;
   assign ng_if.cmd_color_i = cmd_if.cmd_color_i;

   vga_rect_fill #(.GATE_ACTIVE(1)) u_dut (
      .clk_i          (clk_i),
      .arstn_i        (arstn_i),
      .cmd            (cmd_if.slave),
      .abort_i        (abort_i),
      .pixel_enable_i (pixel_enable_i),
      .addr_x_o       (addr_x_o),
      .addr_y_o       (addr_y_o),
      .color_o        (color_o),
      .we_o           (we_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .err_o          (err_o)
   );

   vga_rect_fill #(.GATE_ACTIVE(0)) u_ng (
      .clk_i          (clk_i),
      .arstn_i        (arstn_i),
      .cmd            (ng_if.slave),
      .abort_i        (abort_i),
      .pixel_enable_i (pixel_enable_i),
      .addr_x_o       (ng_addr_x),
      .addr_y_o       (ng_addr_y),
      .color_o        (ng_color),
      .we_o           (ng_we),
      .busy_o         (ng_busy),
      .done_o         (ng_done),
      .err_o          (ng_err)
   );

   always #5 clk_i = ~clk_i;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   pix_t exp_q[$];
   int   wr_cyc[$];
   int   done_cyc[$];
   int   hs_cyc[$];
   int   err_cnt, pe_viol, ng_wr, ng_pe_wr;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk_i) begin : p_mon
      pix_t e;
      if (we_o) begin
         wr_cyc.push_back(cyc);
         if (pixel_enable_i) pe_viol++;
         check("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_x", 32'(addr_x_o), 32'(e.x));
            check("wr_y", 32'(addr_y_o), 32'(e.y));
            check("wr_color", 32'(color_o), 32'(e.c));
         end
      end
      if (done_o) done_cyc.push_back(cyc);
      if (err_o) err_cnt++;
      if (cmd_if.cmd_valid_i && cmd_if.cmd_ready_o) hs_cyc.push_back(cyc);
      if (ng_we) begin
         ng_wr++;
         if (pixel_enable_i) ng_pe_wr++;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear();
      wr_cyc.delete();
      done_cyc.delete();
      hs_cyc.delete();
      err_cnt  = 0;
      pe_viol  = 0;
      ng_wr    = 0;
      ng_pe_wr = 0;
   endtask

   task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                            input int c, input int limit);
      pix_t p;
      int   n = 0;
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            if (n < limit) begin
               p.x = coord_t'(x);
               p.y = coord_t'(y);
               p.c = 2'(c);
               exp_q.push_back(p);
               n++;
            end
   endtask

   task automatic set_fields(input int x0, input int y0, input int x1, input int y1, input int c);
      cmd_if.cmd_x0_i    = coord_t'(x0);
      cmd_if.cmd_y0_i    = coord_t'(y0);
      cmd_if.cmd_x1_i    = coord_t'(x1);
      cmd_if.cmd_y1_i    = coord_t'(y1);
      cmd_if.cmd_color_i = color_e'(c);
   endtask

   // Returns one cycle after the handshake edge, i.e. inside the first fill cycle.
   task automatic drive_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
      int n = 0;
      set_fields(x0, y0, x1, y1, c);
      cmd_if.cmd_valid_i = 1'b1;
      while (!cmd_if.cmd_ready_o && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("ready_timeout", 0, 1);
      tick();
      cmd_if.cmd_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int target, input int bound);
      int n = 0;
      while (done_cyc.size() < target && n < bound) begin
         tick();
         n++;
      end
      check("done_count", done_cyc.size(), target);
   endtask

   initial begin
      arstn_i            = 1'b1;
      abort_i            = 1'b0;
      pixel_enable_i     = 1'b0;
      cmd_if.cmd_valid_i = 1'b0;
      set_fields(0, 0, 0, 0, 0);
      clear();
      #2 arstn_i = 1'b0;
      @(negedge clk_i);
      check("rst_we", we_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_addr", {addr_y_o, addr_x_o}, 0);
      check("rst_color", color_o, 0);
      tick();
      arstn_i = 1'b1;
      tick();
      check("rst_ready", cmd_if.cmd_ready_o, 1);

      // 2x2 rectangle, no stall
      clear();
      push_rect(3, 5, 4, 6, 2, 100);
      drive_cmd(3, 5, 4, 6, 2);
      check("t1_busy", busy_o, 1);
      check("t1_ready_low", cmd_if.cmd_ready_o, 0);
      wait_done(1, 20);
      check("t1_ready_after", cmd_if.cmd_ready_o, 1);
      check("t1_nwr", wr_cyc.size(), 4);
      if (wr_cyc.size() == 4 && hs_cyc.size() == 1 && done_cyc.size() == 1) begin
         check("t1_first_lat", (wr_cyc[0] >= hs_cyc[0] + 1) ? 1 : 0, 1);
         check("t1_b2b", wr_cyc[3] - wr_cyc[0], 3);
         check("t1_done_lat", done_cyc[0] - wr_cyc[3], 1);
      end
      tick();
      tick();
      check("t1_done_pulse", done_cyc.size(), 1);
      check("t1_ng_wr", ng_wr, 4);
      check("t1_sb_empty", exp_q.size(), 0);

      // malformed and out-of-range commands
      clear();
      drive_cmd(10, 0, 9, 0, 1);
      tick();
      tick();
      check("t2_err", err_cnt, 1);
      check("t2_nwr", wr_cyc.size(), 0);
      check("t2_ready", cmd_if.cmd_ready_o, 1);
      check("t2_busy", busy_o, 0);
      drive_cmd(0, 0, 1280, 0, 1);
      tick();
      drive_cmd(0, 0, 0, 1024, 1);
      tick();
      tick();
      check("t2_err_range", err_cnt, 3);
      check("t2_nwr_range", wr_cyc.size(), 0);

      // 8-pixel row with active-video stall in fill cycles 2-4
      clear();
      push_rect(0, 0, 7, 0, 1, 100);
      drive_cmd(0, 0, 7, 0, 1);
      tick();
      pixel_enable_i = 1'b1;
      tick();
      tick();
      tick();
      pixel_enable_i = 1'b0;
      wait_done(1, 30);
      check("t3_nwr", wr_cyc.size(), 8);
      check("t3_pe_viol", pe_viol, 0);
      if (wr_cyc.size() >= 2) check("t3_gap", wr_cyc[1] - wr_cyc[0], 4);
      check("t3_ng_pe_wr", ng_pe_wr, 3);
      check("t3_ng_wr", ng_wr, 8);
      check("t3_sb_empty", exp_q.size(), 0);

      // abort on the 50th write of a 100x100 fill
      clear();
      push_rect(0, 0, 99, 99, 3, 49);
      drive_cmd(0, 0, 99, 99, 3);
      repeat (49) tick();
      abort_i = 1'b1;
      @(negedge clk_i);
      check("t4_abort_we", we_o, 0);
      tick();
      abort_i = 1'b0;
      check("t4_idle_busy", busy_o, 0);
      check("t4_idle_ready", cmd_if.cmd_ready_o, 1);
      repeat (3) tick();
      check("t4_nwr", wr_cyc.size(), 49);
      check("t4_no_done", done_cyc.size(), 0);
      check("t4_sb_empty", exp_q.size(), 0);

      // reset mid-fill, then a 1x1 fill in the far corner
      clear();
      push_rect(0, 0, 9, 9, 1, 5);
      drive_cmd(0, 0, 9, 9, 1);
      repeat (4) tick();
      @(negedge clk_i);
      #2 arstn_i = 1'b0;
      #1;
      check("t5_we", we_o, 0);
      check("t5_busy", busy_o, 0);
      check("t5_done", done_o, 0);
      check("t5_err", err_o, 0);
      check("t5_addr", {addr_y_o, addr_x_o}, 0);
      check("t5_color", color_o, 0);
      tick();
      tick();
      arstn_i = 1'b1;
      tick();
      check("t5_ready", cmd_if.cmd_ready_o, 1);
      check("t5_nwr", wr_cyc.size(), 5);
      check("t5_sb_empty", exp_q.size(), 0);
      clear();
      push_rect(1279, 1023, 1279, 1023, 3, 100);
      drive_cmd(1279, 1023, 1279, 1023, 3);
      wait_done(1, 10);
      check("t5_corner_nwr", wr_cyc.size(), 1);
      check("t5_corner_sb", exp_q.size(), 0);

      // second command held valid during a fill
      clear();
      push_rect(2, 2, 3, 2, 1, 100);
      push_rect(5, 1, 5, 2, 2, 100);
      set_fields(2, 2, 3, 2, 1);
      cmd_if.cmd_valid_i = 1'b1;
      tick();
      set_fields(5, 1, 5, 2, 2);
      for (int n = 0; n < 30; n++) begin
         @(negedge clk_i);
         if (cmd_if.cmd_ready_o) break;
      end
      tick();
      cmd_if.cmd_valid_i = 1'b0;
      wait_done(2, 20);
      check("t6_hs", hs_cyc.size(), 2);
      if (hs_cyc.size() == 2 && done_cyc.size() == 2)
         check("t6_after_done", hs_cyc[1] - done_cyc[0], 1);
      check("t6_nwr", wr_cyc.size(), 4);
      check("t6_sb_empty", exp_q.size(), 0);

      tick();
      check("final_sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
